// File: rtl/imem_port_arbiter_pkg.sv
// Shared widths and requester identifiers for the instruction-memory port arbiter.
package imem_pkg;

    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DEPTH  = 256;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_L = 1'b1
    } req_id_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the loader, the arbiter and the instruction memory.
// The arbiter uses the slave modport; the requesters and the memory sit on the master side.
interface imem_port_arbiter_if #(
    parameter int DATA_W = imem_pkg::IMEM_DATA_W,
    parameter int ADDR_W = imem_pkg::IMEM_ADDR_W
);

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              l_req;
    logic              l_we;
    logic              l_lock;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_rr_pick.sv
// Combinational two-way round-robin picker; lock_hold forces the grant to the loader.
module imem_rr_pick
    import imem_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_winner,
    input  logic       lock_hold,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (lock_hold && req[REQ_L]) begin
            gnt[REQ_L] = 1'b1;
        end else if (req == 2'b01) begin
            gnt = 2'b01;
        end else if (req == 2'b10) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
            // On a tie the requester that did not win last time goes next.
            gnt = (last_winner == REQ_F) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch (read-only) and loader (read/write).
// Optional fetch stall counter is built only when IMEM_ARB_STATS_EN is defined.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int BURST_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus
`ifdef IMEM_ARB_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [15:0]         f_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);

    req_id_t          last_winner;
    logic             lock_active;
    logic [CNT_W-1:0] burst_cnt;
    logic             f_rv_q;
    logic             l_rv_q;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             lock_hold;

    // Requests are masked during reset so no grant or memory command can escape.
    assign req       = rst ? 2'b00 : {bus.l_req, bus.f_req};
    assign lock_hold = lock_active && ((burst_cnt < BURST_MAX_C) || !bus.f_req);

    imem_rr_pick u_pick (
        .req         (req),
        .last_winner (last_winner),
        .lock_hold   (lock_hold),
        .gnt         (gnt)
    );

    assign bus.f_gnt     = gnt[REQ_F];
    assign bus.l_gnt     = gnt[REQ_L];
    assign bus.mem_en    = gnt[REQ_F] | gnt[REQ_L];
    assign bus.mem_we    = gnt[REQ_L] & bus.l_we;
    assign bus.mem_addr  = gnt[REQ_L] ? bus.l_addr : (gnt[REQ_F] ? bus.f_addr : '0);
    assign bus.mem_wdata = gnt[REQ_L] ? bus.l_wdata : '0;

    assign bus.f_rvalid  = f_rv_q;
    assign bus.l_rvalid  = l_rv_q;
    assign bus.f_rdata   = f_rv_q ? bus.mem_rdata : '0;
    assign bus.l_rdata   = l_rv_q ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= REQ_F;
            lock_active <= 1'b0;
            burst_cnt   <= '0;
            f_rv_q      <= 1'b0;
            l_rv_q      <= 1'b0;
        end else begin
            f_rv_q <= gnt[REQ_F];
            l_rv_q <= gnt[REQ_L] & ~bus.l_we;
            if (gnt[REQ_L]) begin
                last_winner <= REQ_L;
            end else if (gnt[REQ_F]) begin
                last_winner <= REQ_F;
            end
            // The lock only survives consecutive locked loader grants; anything else drops it.
            if (gnt[REQ_L] && bus.l_lock) begin
                lock_active <= 1'b1;
                if (burst_cnt != BURST_MAX_C) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                lock_active <= 1'b0;
                burst_cnt   <= '0;
            end
        end
    end

`ifdef IMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_stall_cnt <= '0;
        end else if (stats_clr) begin
            f_stall_cnt <= '0;
        end else if (bus.f_req && !gnt[REQ_F] && (f_stall_cnt != 16'hFFFF)) begin
            f_stall_cnt <= f_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
